// File: rtl/ssqa_ctrl_if.sv
// Control bundle between the ssqa sequencer and the spin-unit array.
// The sequencer owns the master side; spin units and observers use the slave side.
interface ssqa_ctrl_if #(
   parameter int NN        = 800,
   parameter int TEM_WIDTH = 8
);
   localparam int AW = (NN > 1) ? $clog2(NN) : 1;

   logic                        start;
   logic                        busy;
   logic                        done;
   logic                        rst_ini;
   logic                        rst_iter;
   logic                        en_read;
   logic                        en_mult;
   logic                        en_upd;
   logic                        wea;
   logic [AW-1:0]               count_spin;
   logic [AW-1:0]               count_bit;
   logic [15:0]                 count_iter;
   logic signed [TEM_WIDTH-1:0] I0;
   logic signed [TEM_WIDTH-1:0] Q;

   modport master (
      input  start,
      output busy, done, rst_ini, rst_iter, en_read, en_mult, en_upd, wea,
      output count_spin, count_bit, count_iter, I0, Q
   );

   modport slave (
      output start,
      input  busy, done, rst_ini, rst_iter, en_read, en_mult, en_upd, wea,
      input  count_spin, count_bit, count_iter, I0, Q
   );
endinterface

// File: rtl/ssqa_ctrl.sv
// Annealing sequencer for the ssqa spin array: per-spin MAC/update timing,
// spin/bit/iteration counters and the saturating I0 schedule.
module ssqa_ctrl #(
   parameter int N         = 800,
   parameter int NN        = 800,
   parameter int TEM_WIDTH = 8,
   parameter int READ_LAT  = 2,
   parameter int ITER      = 500,
   parameter int TAU       = 10,
   parameter int I0_MIN    = 4,
   parameter int I0_MAX    = 64,
   parameter int I0_STEP   = 4,
   parameter int Q_VAL     = 2
) (
   input  logic          clk,
   input  logic          rst,
   ssqa_ctrl_if.master   bus
);
   localparam int AW = (NN > 1) ? $clog2(NN) : 1;
   localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

   localparam logic [AW-1:0]               LP_LAST      = AW'(N - 1);
   localparam logic [DW-1:0]               LP_DRAIN_END = DW'(READ_LAT - 1);
   localparam logic [15:0]                 LP_ITER      = 16'(ITER);
   localparam logic [15:0]                 LP_TAU_END   = 16'(TAU - 1);
   localparam logic signed [TEM_WIDTH-1:0] LP_I0_MIN    = TEM_WIDTH'(I0_MIN);
   localparam logic signed [TEM_WIDTH-1:0] LP_I0_MAX    = TEM_WIDTH'(I0_MAX);
   localparam logic signed [TEM_WIDTH:0]   LP_MAX_W     = (TEM_WIDTH + 1)'(I0_MAX);
   localparam logic signed [TEM_WIDTH:0]   LP_STEP_W    = (TEM_WIDTH + 1)'(I0_STEP);
   localparam logic signed [TEM_WIDTH-1:0] LP_Q         = TEM_WIDTH'(Q_VAL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_MULT,
      S_DRAIN,
      S_UPD,
      S_DONE
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [AW-1:0]               r_count_spin;
   logic [AW-1:0]               r_count_bit;
   logic [15:0]                 r_count_iter;
   logic [15:0]                 r_tau_cnt;
   logic [DW-1:0]               r_drain_cnt;
   logic signed [TEM_WIDTH-1:0] r_i0;
   logic                        r_iter_pulse;
   logic [READ_LAT-1:0]         r_mult_pipe;
   logic [READ_LAT-1:0]         w_mult_pipe_nxt;

   logic        w_bit_last;
   logic        w_spin_last;
   logic        w_drain_last;
   logic [15:0] w_iter_nxt;
   logic        w_mac_rd;
   logic        w_busy;
   logic        w_done;
   logic        w_rst_ini;
   logic        w_en_read;
   logic        w_en_upd;

   // Sum is one bit wider than I0 so the ceiling compare never sees a wrapped value.
   function automatic logic signed [TEM_WIDTH-1:0] i0_sat_step(
      input logic signed [TEM_WIDTH-1:0] v
   );
      logic signed [TEM_WIDTH:0] w_sum;
      w_sum = $signed({v[TEM_WIDTH-1], v}) + LP_STEP_W;
      if (w_sum > LP_MAX_W) return LP_I0_MAX;
      return w_sum[TEM_WIDTH-1:0];
   endfunction

   assign w_bit_last   = (r_count_bit == LP_LAST);
   assign w_spin_last  = (r_count_spin == LP_LAST);
   assign w_drain_last = (r_drain_cnt == LP_DRAIN_END);
   assign w_iter_nxt   = r_count_iter + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_rst_ini   = 1'b0;
      w_en_read   = 1'b0;
      w_en_upd    = 1'b0;
      w_mac_rd    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = S_INIT;
         end
         S_INIT: begin
            w_busy      = 1'b1;
            w_rst_ini   = 1'b1;
            w_state_nxt = S_MULT;
         end
         S_MULT: begin
            w_busy    = 1'b1;
            w_en_read = 1'b1;
            w_mac_rd  = 1'b1;
            if (w_bit_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_drain_last) w_state_nxt = S_UPD;
         end
         S_UPD: begin
            w_busy    = 1'b1;
            w_en_read = 1'b1;
            w_en_upd  = 1'b1;
            if (w_spin_last && (w_iter_nxt == LP_ITER)) w_state_nxt = S_DONE;
            else                                        w_state_nxt = S_MULT;
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Only MAC reads feed the delay line; the UPD read belongs to the write-back path.
   always_comb begin
      w_mult_pipe_nxt    = r_mult_pipe << 1;
      w_mult_pipe_nxt[0] = w_mac_rd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count_spin <= '0;
         r_count_bit  <= '0;
         r_count_iter <= '0;
         r_tau_cnt    <= '0;
         r_drain_cnt  <= '0;
         r_i0         <= LP_I0_MIN;
         r_iter_pulse <= 1'b0;
         r_mult_pipe  <= '0;
      end else begin
         r_mult_pipe  <= w_mult_pipe_nxt;
         r_iter_pulse <= 1'b0;
         unique case (r_state)
            S_IDLE, S_INIT: begin
               if (r_state == S_INIT || bus.start) begin
                  r_count_spin <= '0;
                  r_count_bit  <= '0;
                  r_count_iter <= '0;
                  r_tau_cnt    <= '0;
                  r_i0         <= LP_I0_MIN;
               end
            end
            S_MULT: begin
               r_drain_cnt <= '0;
               if (!w_bit_last) r_count_bit <= r_count_bit + AW'(1);
            end
            S_DRAIN: begin
               r_drain_cnt <= r_drain_cnt + DW'(1);
            end
            S_UPD: begin
               r_count_bit <= '0;
               if (!w_spin_last) begin
                  r_count_spin <= r_count_spin + AW'(1);
               end else begin
                  r_count_spin <= '0;
                  r_count_iter <= w_iter_nxt;
                  r_iter_pulse <= (w_iter_nxt != LP_ITER);
                  // Iteration-boundary I0 step every TAU completed iterations.
                  if (r_tau_cnt == LP_TAU_END) begin
                     r_tau_cnt <= '0;
                     r_i0      <= i0_sat_step(r_i0);
                  end else begin
                     r_tau_cnt <= r_tau_cnt + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.rst_ini    = w_rst_ini;
   assign bus.rst_iter   = w_rst_ini | r_iter_pulse;
   assign bus.en_read    = w_en_read;
   assign bus.en_mult    = r_mult_pipe[READ_LAT-1];
   assign bus.en_upd     = w_en_upd;
   assign bus.wea        = w_en_upd;
   assign bus.count_spin = r_count_spin;
   assign bus.count_bit  = r_count_bit;
   assign bus.count_iter = r_count_iter;
   assign bus.I0         = r_i0;
   assign bus.Q          = LP_Q;
endmodule

// File: tb/tb_ssqa_ctrl.sv
// Directed bench for ssqa_ctrl: N=4 job timing/abort, N=1 I0 schedule,
// and a cycle table for an N=1, ITER=2 job.
module tb_ssqa_ctrl;
   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   ssqa_ctrl_if #(.NN(8), .TEM_WIDTH(8)) a_if ();
   ssqa_ctrl_if #(.NN(2), .TEM_WIDTH(8)) b_if ();
   ssqa_ctrl_if #(.NN(2), .TEM_WIDTH(8)) c_if ();

   ssqa_ctrl #(.N(4), .NN(8), .TEM_WIDTH(8), .READ_LAT(2), .ITER(3), .TAU(2),
               .I0_MIN(4), .I0_MAX(10), .I0_STEP(4), .Q_VAL(2))
      u_a (.clk(clk), .rst(rst_a), .bus(a_if));
   ssqa_ctrl #(.N(1), .NN(2), .TEM_WIDTH(8), .READ_LAT(2), .ITER(8), .TAU(2),
               .I0_MIN(4), .I0_MAX(10), .I0_STEP(4), .Q_VAL(2))
      u_b (.clk(clk), .rst(rst_b), .bus(b_if));
   ssqa_ctrl #(.N(1), .NN(2), .TEM_WIDTH(8), .READ_LAT(2), .ITER(2), .TAU(2),
               .I0_MIN(4), .I0_MAX(10), .I0_STEP(4), .Q_VAL(2))
      u_c (.clk(clk), .rst(rst_c), .bus(c_if));

   // Flag order: busy, done, rst_ini, rst_iter, en_read, en_mult, en_upd
   wire [6:0] a_flags = {a_if.busy, a_if.done, a_if.rst_ini, a_if.rst_iter,
                         a_if.en_read, a_if.en_mult, a_if.en_upd};
   wire [6:0] c_flags = {c_if.busy, c_if.done, c_if.rst_ini, c_if.rst_iter,
                         c_if.en_read, c_if.en_mult, c_if.en_upd};

   typedef struct {
      logic        start;
      logic [6:0]  flags;
      logic [15:0] iter;
      int          i0;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic job_a(input bit poke);
      int t_done = -1, n_ini = 0, n_upd = 0, n_mult = 0, n_busy = 0, n_done = 0;
      int bad_spin = 0, bad_i0 = 0, bad_misc = 0, eb;
      int iterp[$];
      int ea[3];
      int ep[3];
      logic [6:0] e_rd, e_mult, e_upd;
      logic signed [7:0] prev_i0;
      ea = '{4, 4, 8};
      ep = '{0, 29, 57};
      e_rd = 7'b1001111;
      e_mult = 7'b0111100;
      e_upd = 7'b1000000;
      a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      prev_i0 = a_if.I0;
      for (int t = 0; t < 120; t++) begin
         if (t > 0) @(negedge clk);
         if (t == 0) chk("A init flags", 32'(a_flags), 32'(7'b1011000));
         if (t >= 1 && t <= 7) begin
            eb = (t - 1 < 4) ? t - 1 : 3;
            chk($sformatf("A spin0 cyc%0d", t - 1),
                32'({a_if.en_read, a_if.en_mult, a_if.en_upd, a_if.count_bit,
                     a_if.count_spin, a_if.count_iter}),
                32'({e_rd[t-1], e_mult[t-1], e_upd[t-1], 3'(eb), 3'd0, 16'd0}));
         end
         if (a_if.rst_ini) n_ini++;
         if (a_if.rst_iter) iterp.push_back(t);
         if (a_if.en_mult) n_mult++;
         if (a_if.busy) n_busy++;
         if (a_if.wea !== a_if.en_upd || a_if.Q !== 8'sd2 || a_if.count_iter > 16'd3) bad_misc++;
         if (a_if.en_mult && a_if.I0 != prev_i0) bad_i0++;
         prev_i0 = a_if.I0;
         if (a_if.en_upd) begin
            if (n_upd >= 12 || a_if.count_spin != 3'(n_upd % 4) ||
                a_if.count_iter != 16'(n_upd / 4) || int'(a_if.I0) != ea[(n_upd / 4) % 3])
               bad_spin++;
            n_upd++;
         end
         a_if.start = (poke && t == 10);
         if (a_if.done) begin
            n_done++;
            t_done = t;
            chk("A done count_iter", 32'(a_if.count_iter), 3);
            chk("A done count_spin", 32'(a_if.count_spin), 0);
            chk("A done I0", int'(a_if.I0), 8);
            a_if.start = poke;
            break;
         end
      end
      @(negedge clk);
      a_if.start = 1'b0;
      chk("A idle after done", 32'(a_flags), 0);
      @(negedge clk);
      chk("A start in DONE ignored", 32'(a_flags), 0);
      chk("A rst_ini pulses", n_ini, 1);
      chk("A rst_iter pulses", iterp.size(), 3);
      for (int i = 0; i < iterp.size() && i < 3; i++)
         chk($sformatf("A rst_iter time%0d", i), iterp[i], ep[i]);
      chk("A done time", t_done, 85);
      chk("A done pulses", n_done, 1);
      chk("A en_upd pulses", n_upd, 12);
      chk("A en_mult cycles", n_mult, 48);
      chk("A busy cycles", n_busy, 85);
      chk("A upd spin/iter/I0", bad_spin, 0);
      chk("A I0 change under en_mult", bad_i0, 0);
      chk("A wea/Q/iter range", bad_misc, 0);
   endtask

   task automatic abort_a();
      int found = 0, seen_busy = 0, seen_done = 0;
      a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (a_if.done) seen_done++;
         if (a_if.en_read && !a_if.en_upd && a_if.count_spin == 3'd2 && a_if.count_bit == 3'd2) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("A abort point reached", found, 1);
      #1 rst_a = 1'b1;
      #1;
      chk("A abort flags", 32'({a_flags, a_if.wea}), 0);
      chk("A abort counters", 32'({a_if.count_spin, a_if.count_bit, a_if.count_iter}), 0);
      chk("A abort I0", int'(a_if.I0), 4);
      @(negedge clk);
      rst_a = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (a_if.busy) seen_busy++;
         if (a_if.done) seen_done++;
      end
      chk("A no busy after abort", seen_busy, 0);
      chk("A no done on abort", seen_done, 0);
   endtask

   task automatic job_b();
      int t_done = -1, n_upd = 0, bad_per = 0, bad_i0 = 0;
      int eb[8];
      logic signed [7:0] prev_i0;
      eb = '{4, 4, 8, 8, 10, 10, 10, 10};
      b_if.start = 1'b1;
      @(negedge clk);
      b_if.start = 1'b0;
      prev_i0 = b_if.I0;
      for (int t = 0; t < 100; t++) begin
         if (t > 0) @(negedge clk);
         if (b_if.en_mult && b_if.I0 != prev_i0) bad_i0++;
         prev_i0 = b_if.I0;
         if (b_if.en_upd) begin
            if (t != 4 + 4 * n_upd || b_if.count_iter != 16'(n_upd)) bad_per++;
            if (n_upd < 8) chk($sformatf("B I0 iter%0d", n_upd), int'(b_if.I0), eb[n_upd]);
            n_upd++;
         end
         if (b_if.done) begin
            t_done = t;
            chk("B final I0", int'(b_if.I0), 10);
            chk("B final count_iter", 32'(b_if.count_iter), 8);
            break;
         end
      end
      chk("B done time", t_done, 33);
      chk("B en_upd pulses", n_upd, 8);
      chk("B spin period/iter step", bad_per, 0);
      chk("B I0 change under en_mult", bad_i0, 0);
   endtask

   initial begin
      tv[0]  = '{1'b1, 7'b0000000, 16'd0, 4};
      tv[1]  = '{1'b0, 7'b1011000, 16'd0, 4};
      tv[2]  = '{1'b0, 7'b1000100, 16'd0, 4};
      tv[3]  = '{1'b0, 7'b1000000, 16'd0, 4};
      tv[4]  = '{1'b0, 7'b1000010, 16'd0, 4};
      tv[5]  = '{1'b0, 7'b1000101, 16'd0, 4};
      tv[6]  = '{1'b0, 7'b1001100, 16'd1, 4};
      tv[7]  = '{1'b0, 7'b1000000, 16'd1, 4};
      tv[8]  = '{1'b0, 7'b1000010, 16'd1, 4};
      tv[9]  = '{1'b0, 7'b1000101, 16'd1, 4};
      tv[10] = '{1'b1, 7'b0100000, 16'd2, 8};
      tv[11] = '{1'b0, 7'b0000000, 16'd2, 8};
      tv[12] = '{1'b1, 7'b0000000, 16'd2, 8};
      tv[13] = '{1'b0, 7'b1011000, 16'd0, 4};
      tv[14] = '{1'b0, 7'b1000100, 16'd0, 4};
      tv[15] = '{1'b0, 7'b1000000, 16'd0, 4};

      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      a_if.start = 1'b0;
      b_if.start = 1'b0;
      c_if.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      @(negedge clk);
      chk("A reset flags", 32'({a_flags, a_if.wea}), 0);
      chk("A reset counters", 32'({a_if.count_spin, a_if.count_bit, a_if.count_iter}), 0);
      chk("A reset I0", int'(a_if.I0), 4);
      chk("A reset Q", int'(a_if.Q), 2);

      job_a(1'b1);
      abort_a();
      job_a(1'b0);
      job_b();

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         c_if.start = tv[i].start;
         chk($sformatf("C v%0d flags", i), 32'(c_flags), 32'(tv[i].flags));
         chk($sformatf("C v%0d count_iter", i), 32'(c_if.count_iter), 32'(tv[i].iter));
         chk($sformatf("C v%0d I0", i), int'(c_if.I0), tv[i].i0);
         chk($sformatf("C v%0d wea", i), 32'(c_if.wea), 32'(tv[i].flags[0]));
      end
      c_if.start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/ssqa_ctrl.md
Name: ssqa_ctrl

Overview:
Central sequencer that drives the array of ssqa spin units. It generates the BRAM read/write enables, multiply-accumulate and update strobes, the spin/bit/iteration address counters, and the annealing schedule for I0 and Q. Every spin unit's control inputs connect directly to this block's outputs. The block runs one full annealing job per start pulse.

Parameters:
N, 800, number of spins updated per iteration.
NN, 800, BRAM depth; address width is $clog2(NN); N <= NN.
TEM_WIDTH, 8, width of the signed I0 and Q outputs.
READ_LAT, 2, BRAM read latency in clk cycles (address to doutb).
ITER, 500, number of iterations per job; 1..65535.
TAU, 10, number of completed iterations between I0 steps.
I0_MIN, 4, initial I0 value (signed TEM_WIDTH).
I0_MAX, 64, I0 saturation ceiling (signed TEM_WIDTH); I0_MIN <= I0_MAX < 2^(TEM_WIDTH-1).
I0_STEP, 4, I0 increment per TAU iterations.
Q_VAL, 2, inter-layer coupling driven on Q.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle job start; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse when the last update of iteration ITER-1 completes
rst_ini  out  1  one-cycle pulse at job start
rst_iter  out  1  one-cycle pulse at the start of each iteration
en_read  out  1  BRAM read enable
en_mult  out  1  accumulate strobe, aligned with BRAM data
en_upd  out  1  spin update/write strobe
wea  out  1  BRAM write enable; equal to en_upd
count_spin  out  $clog2(NN)  spin currently being updated
count_bit  out  $clog2(NN)  spin currently being read for the MAC
count_iter  out  16  current iteration index
I0  out  TEM_WIDTH  signed saturation bound
Q  out  TEM_WIDTH  signed inter-layer coupling

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All 1-bit outputs = 0; all counters = 0; I0 = I0_MIN; Q = Q_VAL. The en_mult delay pipe is cleared.
- FSM states: IDLE, INIT, MULT, DRAIN, UPD, DONE.
- IDLE: waits for start = 1, then goes to INIT.
- INIT: lasts 1 cycle.
  - rst_ini = 1 and rst_iter = 1.
  - count_spin, count_bit and count_iter are set to 0; I0 = I0_MIN.
  - Next state is MULT.
- MULT: lasts N cycles.
  - en_read = 1.
  - count_bit steps 0..N-1, one value per cycle.
  - After the cycle with count_bit = N-1, go to DRAIN.
- en_mult: en_read delayed by exactly READ_LAT cycles (shift register). The k-th asserted en_mult therefore coincides with the data for count_bit = k.
- DRAIN: lasts READ_LAT cycles.
  - en_read = 0; count_bit holds at N-1.
  - The delayed en_mult flushes during this state.
  - Next state is UPD.
- UPD: lasts 1 cycle.
  - en_upd = 1, wea = 1, en_read = 1.
  - count_bit is reset to 0 at the end of the cycle.
  - If count_spin < N-1: count_spin increments and the FSM returns to MULT.
  - Otherwise count_spin wraps to 0 and count_iter increments:
    - if the new count_iter = ITER, go to DONE;
    - otherwise pulse rst_iter in the first MULT cycle of the new iteration and go to MULT.
- count_spin is stable for the whole MULT, DRAIN and UPD sequence of one spin. Cycles per spin = N + READ_LAT + 1; cycles per iteration = N·(N + READ_LAT + 1).
- I0 schedule: at each iteration boundary where the new count_iter is a nonzero multiple of TAU, I0 <= min(I0 + I0_STEP, I0_MAX). The addition is computed one bit wider than TEM_WIDTH, so the saturation check cannot overflow. I0 changes only at iteration boundaries, never mid-iteration.
- Q is held at Q_VAL throughout.
- DONE: lasts 1 cycle.
  - done = 1 and busy drops to 0 in the same cycle.
  - count_iter holds at ITER, count_spin = 0, I0 holds its final value.
  - Next state is IDLE.
- start is ignored in every state except IDLE. If start and the DONE cycle coincide, start is ignored.
- An assertion of rst mid-job aborts the job immediately. No done pulse is produced. After rst deasserts, a new start is required.
- N = 1: MULT lasts 1 cycle and every UPD ends an iteration.
- count_iter never exceeds ITER; 16-bit wrap-around is unreachable.

Test Plan:
- N=4, READ_LAT=2, ITER=1, pulse start -> rst_ini and rst_iter high for 1 cycle; en_read high 4 cycles (count_bit 0,1,2,3); en_mult high exactly 4 cycles, lagging en_read by 2; en_upd high 1 cycle with count_spin=0; spin period = 7 cycles; done pulse 28 cycles after MULT begins.
- N=4, ITER=3 -> rst_iter pulses at iterations 1 and 2, each exactly 28 cycles apart; count_iter reads 0,1,2 during the run and 3 at done; exactly 12 en_upd pulses in total.
- TAU=2, I0_MIN=4, I0_STEP=4, I0_MAX=10, ITER=8 -> I0 = 4,4,8,8,10,10,10,10 across iterations 0..7; I0 never changes while en_mult=1.
- Assert rst in the 3rd MULT cycle of spin 2 -> all outputs 0 and state IDLE in the same cycle; no done pulse; a new start restarts the job from count_spin=0, count_iter=0.
- Pulse start while busy=1, and again during the DONE cycle -> no effect on counters or timing; a start in the following IDLE cycle launches a new job.
- N=1, ITER=2 -> each spin period = 4 cycles (MULT 1 + DRAIN 2 + UPD 1); count_iter increments on every en_upd; done asserted after 8 cycles.
